// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped 8N1 UART transmitter, byte FIFO plus status register (build option UART_TX_FLOW_EN).
// Latency: push at cycle N -> FIFO count at N+1 -> start bit on uart_txd at N+2; each frame is 10*CLKS_PER_BIT cycles.
// Backpressure: none toward the bus; a push to a full FIFO is dropped and sets sticky overflow; with UART_TX_FLOW_EN frame starts wait for uart_rts low.
module uart_tx_peripheral #(
  parameter logic [63:0] BASE_ADDRESS = 64'h0000_0000_0000_0400,
  parameter int          CLKS_PER_BIT = 217,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [63:0] address,
  input  logic        read,
  input  logic        write,
  output logic        uart_txd,
  input  logic        uart_rts
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [63:0]   STAT_ADDRESS = BASE_ADDRESS + 64'd1;
  localparam logic [BW-1:0] BAUD_LAST    = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            wr_hit_q, rd_hit_q;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            wr_hit, rd_hit, push, accept, pop;
  logic            fifo_empty, fifo_full, can_start, baud_end;
  logic [63:0]     status;
  logic            unused_bus;

  assign unused_bus = ^data[63:8];

`ifdef UART_TX_FLOW_EN
  logic rts_q;
  assign can_start = !fifo_empty && !rts_q;
`else
  logic unused_rts;
  assign unused_rts = uart_rts;
  assign can_start  = !fifo_empty;
`endif

  // Bus decode: a data-register write pushes only on the first cycle of a held strobe.
  always_comb begin
    wr_hit     = write && (address == BASE_ADDRESS);
    rd_hit     = read && (address == STAT_ADDRESS);
    push       = wr_hit && !wr_hit_q;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    accept     = push && !fifo_full;
  end

  // Status word reflects registered state; the bus is driven only during a status read.
  always_comb begin
    status      = '0;
    status[0]   = fifo_empty;
    status[1]   = fifo_full;
    status[2]   = (state_q != S_IDLE);
    status[3]   = ovf_q;
    status[8:4] = 5'(count_q);
`ifdef UART_TX_FLOW_EN
    status[9]   = rts_q;
`endif
  end

  assign data = rd_hit ? status : 'z;

  // Transmit FSM: next state, baud/bit counters, shift register and line level.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    uart_txd = 1'b1;
    baud_end = (baud_q == BAUD_LAST);
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = mem_q[head_q];
          state_d = S_START;
        end
      end
      S_START: begin
        uart_txd = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        uart_txd = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (can_start) begin
            pop     = 1'b1;
            shift_d = mem_q[head_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow (set wins over a same-cycle read clear).
  always_comb begin
    head_d  = pop ? head_q + 1'b1 : head_q;
    tail_d  = accept ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(accept) - CW'(pop);
    if (push && fifo_full)        ovf_d = 1'b1;
    else if (rd_hit && !rd_hit_q) ovf_d = 1'b0;
    else                          ovf_d = ovf_q;
  end

  // State registers with synchronous reset; FIFO contents are discarded by clearing the pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      wr_hit_q <= 1'b0;
      rd_hit_q <= 1'b0;
`ifdef UART_TX_FLOW_EN
      rts_q    <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      wr_hit_q <= wr_hit;
      rd_hit_q <= rd_hit;
`ifdef UART_TX_FLOW_EN
      rts_q    <= uart_rts;
`endif
    end
  end

  // FIFO storage; no reset needed since occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (accept) mem_q[tail_q] <= data[7:0];
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// tb_uart_tx_peripheral: bus-level stimulus with a frame scoreboard and a cycle-exact line receiver.
// Latency: runs with CLKS_PER_BIT=4 so each frame is 40 cycles.
// Backpressure: exercises FIFO overflow and, when built with UART_TX_FLOW_EN, uart_rts gating.
module tb_uart_tx_peripheral;
  localparam logic [63:0] BASE = 64'h0000_0000_0000_0400;
  localparam logic [63:0] STAT = 64'h0000_0000_0000_0401;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic        uart_rts;
  logic        uart_txd;
  logic [63:0] address;
  logic [63:0] tb_wdat;
  logic        tb_drv;
  wire  [63:0] data;

  assign data = tb_drv ? tb_wdat : 'z;

  uart_tx_peripheral #(
    .BASE_ADDRESS(BASE),
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data(data),
    .address(address),
    .read(read),
    .write(write),
    .uart_txd(uart_txd),
    .uart_rts(uart_rts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] byt;
    logic [9:0] frame;
  } vec_t;

  vec_t        vecs [6];
  int          checks = 0;
  int          errors = 0;
  logic [9:0]  sb_q [$];
  int          starts_q [$];
  int          cyc = 0;
  logic        in_frame = 1'b0;
  int          fpos = 0;
  logic [39:0] cap;
  logic [39:0] e40;
  logic [9:0]  ef;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Line receiver: 40 samples per frame starting at the first low cycle, compared against the scoreboard.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (uart_txd == 1'b0) begin
        in_frame = 1'b1;
        fpos     = 1;
        cap      = '0;
        starts_q.push_back(cyc);
      end
    end else begin
      cap[fpos] = uart_txd;
      fpos++;
      if (fpos == 40) begin
        in_frame = 1'b0;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%0h required=none", cap);
        end else begin
          ef = sb_q.pop_front();
          for (int k = 0; k < 40; k++) e40[k] = ef[k/4];
          chk("frame", cap, e40);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_push(input logic [7:0] b, input int hold);
    address = BASE;
    tb_wdat = {56'h0, b};
    tb_drv  = 1'b1;
    write   = 1'b1;
    tick(hold);
    write   = 1'b0;
    tb_drv  = 1'b0;
    address = '0;
  endtask

  task automatic status_read(output logic [63:0] v);
    address = STAT;
    read    = 1'b1;
    #1;
    v = data;
    tick(1);
    read    = 1'b0;
    address = '0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int i = 0;
    while (sb_q.size() != 0 && i < bound) begin
      tick(1);
      i++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
    tick(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int          n;
    int          good;

    vecs[0] = '{8'h00, 10'b1000000000};
    vecs[1] = '{8'hFF, 10'b1111111110};
    vecs[2] = '{8'h01, 10'b1000000010};
    vecs[3] = '{8'h80, 10'b1100000000};
    vecs[4] = '{8'h5A, 10'b1010110100};
    vecs[5] = '{8'hA5, 10'b1101001010};

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0;
    tb_drv = 1'b0; tb_wdat = '0; uart_rts = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("reset_txd", uart_txd, 1'b1);
    tick(50);
    chk("idle_txd", uart_txd, 1'b1);
    status_read(v);
    chk("reset_status", v, 64'h1);

    // First-frame latency and busy duration for 0xA5.
    sb_q.push_back({1'b1, 8'hA5, 1'b0});
    bus_push(8'hA5, 1);
    address = STAT;
    read    = 1'b1;
    #1;
    chk("lat_n1_status", data, 64'h10);
    chk("lat_n1_txd", uart_txd, 1'b1);
    tick(1);
    #1;
    chk("lat_n2_txd", uart_txd, 1'b0);
    chk("lat_n2_status", data, 64'h5);
    n = 1;
    while (n < 100) begin
      tick(1);
      #1;
      if (data[2] == 1'b0) break;
      n++;
    end
    chk("busy_len", n, 40);
    read = 1'b0;
    address = '0;
    tick(2);
    chk("a5_drained", sb_q.size(), 0);

    // Table of bytes with their hand-written line frames.
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(vecs[i].frame);
      bus_push(vecs[i].byt, 1);
      wait_drain("vec", 200);
      status_read(v);
      chk("vec_idle_status", v, 64'h1);
    end

    // A held write pushes once; count is 1 while an earlier frame is in flight.
    sb_q.push_back({1'b1, 8'h96, 1'b0});
    bus_push(8'h96, 1);
    tick(2);
    sb_q.push_back({1'b1, 8'h3C, 1'b0});
    bus_push(8'h3C, 5);
    status_read(v);
    chk("held_write_status", v, 64'h14);
    wait_drain("held", 300);
    status_read(v);
    chk("held_idle_status", v, 64'h1);

    // 18 pushes: first pops at once, next 16 fill the FIFO, the 18th overflows.
    starts_q.delete();
    for (int i = 0; i < 18; i++) begin
      if (i < 17) sb_q.push_back({1'b1, 8'(8'h10 + i), 1'b0});
      bus_push(8'(8'h10 + i), 1);
      tick(1);
    end
    status_read(v);
    chk("ovf_status_set", v, 64'h10E);
    tick(1);
    status_read(v);
    chk("ovf_status_clr", v, 64'h106);
    wait_drain("burst", 17 * 40 + 200);
    good = 0;
    for (int i = 1; i < starts_q.size(); i++)
      if (starts_q[i] - starts_q[i-1] == 40) good++;
    chk("b2b_gaps", good, 16);
    chk("burst_frames", starts_q.size(), 17);
    status_read(v);
    chk("burst_idle_status", v, 64'h1);

    // Reset during data bit 3 aborts the frame and discards queued bytes.
    sb_q.push_back({1'b1, 8'hC3, 1'b0});
    bus_push(8'hC3, 1);
    tick(1);
    bus_push(8'h7E, 1);
    n = 0;
    while (uart_txd && n < 20) begin
      tick(1);
      n++;
    end
    tick(17);
    reset = 1'b1;
    tick(1);
    chk("midreset_txd", uart_txd, 1'b1);
    reset = 1'b0;
    sb_q.delete();
    starts_q.delete();
    status_read(v);
    chk("midreset_status", v, 64'h1);
    tick(100);
    chk("midreset_no_frames", starts_q.size(), 0);
    chk("midreset_txd_idle", uart_txd, 1'b1);

`ifdef UART_TX_FLOW_EN
    uart_rts = 1'b1;
    tick(2);
    sb_q.push_back({1'b1, 8'h55, 1'b0});
    bus_push(8'h55, 1);
    tick(10);
    chk("rts_hold_txd", uart_txd, 1'b1);
    status_read(v);
    chk("rts_hold_status", v, 64'h210);
    uart_rts = 1'b0;
    n = 0;
    while (uart_txd && n < 10) begin
      tick(1);
      n++;
    end
    chk("rts_start_lat", n, 2);
    tick(10);
    uart_rts = 1'b1;
    wait_drain("rts", 200);
    status_read(v);
    chk("rts_done_status", v, 64'h201);
    uart_rts = 1'b0;
    tick(2);
`else
    uart_rts = 1'b1;
    sb_q.push_back({1'b1, 8'h55, 1'b0});
    bus_push(8'h55, 1);
    tick(1);
    chk("rts_ignored_txd", uart_txd, 1'b0);
    status_read(v);
    chk("rts_ignored_status", v, 64'h5);
    wait_drain("rts", 200);
    uart_rts = 1'b0;
`endif

    chk("sb_empty_end", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
